// File: rtl/fdxe_bank_pkg.sv
// Shared types for the fdxe flip-flop bank.
// fdxe_mode_e  : selects whether a cell honours clr (forces 0) or pre (forces 1)
// force_value  : level a cell takes while its override is active
package fdxe_bank_pkg;

    typedef enum logic {
        FDXE_CLEAR  = 1'b0,
        FDXE_PRESET = 1'b1
    } fdxe_mode_e;

    function automatic logic force_value(input fdxe_mode_e mode);
        return (mode == FDXE_PRESET);
    endfunction

endpackage : fdxe_bank_pkg

// File: rtl/fdxe_cell.sv
// Single flip-flop with clock enable and one override, clear- or preset-type.
// Parameters: INIT_BIT (power-up/reset value), IS_SET (1 = preset-type).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset to INIT_BIT
//   d    data input
//   ce   clock enable
//   clr  clear override, used only when IS_SET = 0
//   pre  preset override, used only when IS_SET = 1
//   q    output; forced combinationally while the override is high
module fdxe_cell
    import fdxe_bank_pkg::*;
#(
    parameter logic INIT_BIT = 1'b0,
    parameter logic IS_SET   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic ce,
    input  logic clr,
    input  logic pre,
    output logic q
);

    localparam fdxe_mode_e MODE      = fdxe_mode_e'(IS_SET);
    localparam logic       FORCE_VAL = force_value(MODE);

    // Power-up value comes from the declaration so no edge is needed.
    logic state = INIT_BIT;
    logic ovr;

    // Only the override that matches this cell's mode is looked at; the
    // other one is ignored completely.
    assign ovr = (MODE == FDXE_PRESET) ? pre : clr;

    // Override beats reset, reset beats enable.
    always_ff @(posedge clk) begin
        if (ovr) begin
            state <= FORCE_VAL;
        end else if (rst) begin
            state <= INIT_BIT;
        end else if (ce) begin
            state <= d;
        end
    end

    // Zero-latency override; once an edge absorbs it, state already
    // equals the forced level so release does not glitch.
    assign q = ovr ? FORCE_VAL : state;

endmodule : fdxe_cell

// File: rtl/fdxe_bank.sv
// Portable replacement for a bank of FDCE/FDPE primitives with clock enable.
// Parameters: WIDTH (1..64), INIT (per-bit reset value), SET_MASK
//   (per-bit mode: 1 = preset-type, 0 = clear-type).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, state <= INIT
//   d    per-bit data input
//   ce   per-bit clock enable
//   clr  per-bit clear override (clear-type bits only)
//   pre  per-bit preset override (preset-type bits only)
//   q    per-bit outputs
module fdxe_bank #(
    parameter int                WIDTH    = 8,
    parameter logic [WIDTH-1:0]  INIT     = '0,
    parameter logic [WIDTH-1:0]  SET_MASK = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] ce,
    input  logic [WIDTH-1:0] clr,
    input  logic [WIDTH-1:0] pre,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fdxe_cell #(
            .INIT_BIT (INIT[i]),
            .IS_SET   (SET_MASK[i])
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .d   (d[i]),
            .ce  (ce[i]),
            .clr (clr[i]),
            .pre (pre[i]),
            .q   (q[i])
        );
    end

endmodule : fdxe_bank

// File: tb/tb_fdxe_bank.sv
module tb_fdxe_bank;

    localparam int         W     = 8;
    localparam logic [7:0] INITV = 8'hA5;
    localparam logic [7:0] SMASK = 8'hF0;

    logic         clk;
    logic         rst;
    logic [W-1:0] d, ce, clr, pre, q;

    int n_vec;
    int n_bad;

    fdxe_bank #(
        .WIDTH    (W),
        .INIT     (INITV),
        .SET_MASK (SMASK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .ce  (ce),
        .clr (clr),
        .pre (pre),
        .q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic [7:0] ce;
        logic [7:0] clr;
        logic [7:0] pre;
        logic [7:0] exp_q;   // q seen after inputs settle, before the next edge
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [7:0] exp);
        n_vec++;
        if (q !== exp) begin
            n_bad++;
            $display("FAIL %s: q=%h expected %h at %0t", name, q, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] dd, input logic [7:0] cc,
                         input logic [7:0] cl, input logic [7:0] pr);
        rst = r; d = dd; ce = cc; clr = cl; pre = pr;
    endtask

    // Behavioural reference for the random phase.
    logic [7:0] m_state;

    function automatic logic [7:0] model_q(input logic [7:0] s, input logic [7:0] cl,
                                           input logic [7:0] pr);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (SMASK[i]) r[i] = pr[i] ? 1'b1 : s[i];
            else          r[i] = cl[i] ? 1'b0 : s[i];
        end
        return r;
    endfunction

    function automatic logic [7:0] model_next(input logic [7:0] s, input logic r,
                                              input logic [7:0] dd, input logic [7:0] cc,
                                              input logic [7:0] cl, input logic [7:0] pr);
        logic [7:0] n;
        logic       ov;
        for (int i = 0; i < 8; i++) begin
            ov = SMASK[i] ? pr[i] : cl[i];
            if (ov)        n[i] = SMASK[i];
            else if (r)    n[i] = INITV[i];
            else if (cc[i]) n[i] = dd[i];
            else           n[i] = s[i];
        end
        return n;
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        //            rst   d      ce     clr    pre    exp_q
        tbl[0]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
        tbl[1]  = '{1'b0, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'hA5};
        tbl[2]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h3C};
        tbl[3]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h3C};
        tbl[4]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h3C};
        tbl[5]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h3C};
        tbl[6]  = '{1'b0, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h3C};
        tbl[7]  = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        tbl[8]  = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hF0};
        tbl[9]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};
        tbl[10] = '{1'b0, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'hF0};
        tbl[11] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFE};
        tbl[12] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFE};
        tbl[13] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
        tbl[14] = '{1'b1, 8'h00, 8'hFF, 8'h01, 8'h80, 8'hA4};
        tbl[15] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA4};
        tbl[16] = '{1'b0, 8'h00, 8'h00, 8'hF0, 8'h0F, 8'hA4};
        tbl[17] = '{1'b0, 8'h0F, 8'h0F, 8'h00, 8'hF0, 8'hF4};
        tbl[18] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};

        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        #1;
        check("powerup", 8'hA5);

        for (int v = 0; v < 19; v++) begin
            drive(tbl[v].rst, tbl[v].d, tbl[v].ce, tbl[v].clr, tbl[v].pre);
            #1;
            check($sformatf("vec%0d", v), tbl[v].exp_q);
            @(posedge clk);
            #1;
        end

        // Clear pulse that sees no edge: forced while high, then state reappears.
        drive(1'b0, 8'h00, 8'h00, 8'h01, 8'h00);
        #1;
        check("clr_pulse_on", 8'hFE);
        #2;
        clr = 8'h00;
        #1;
        check("clr_pulse_off", 8'hFF);
        @(posedge clk);
        #1;

        // Same for a preset on a preset-type bit, after clearing it first.
        drive(1'b0, 8'h00, 8'h80, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h80);
        #1;
        check("pre_pulse_on", 8'hFF);
        #2;
        pre = 8'h00;
        #1;
        check("pre_pulse_off", 8'h7F);
        @(posedge clk);
        #1;

        // Clear held across an edge with ce/d trying to set the bit, then released.
        drive(1'b0, 8'h81, 8'h81, 8'h01, 8'h00);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        #1;
        check("clr_held_release", 8'hFE);
        @(posedge clk);
        #1;
        check("clr_held_stays", 8'hFE);

        // Random phase against the behavioural model.
        m_state = 8'hFE;
        for (int c = 0; c < 2000; c++) begin
            drive(($urandom_range(0, 15) == 0),
                  8'($urandom),
                  8'($urandom),
                  8'($urandom) & 8'($urandom) & 8'($urandom),
                  8'($urandom) & 8'($urandom) & 8'($urandom));
            #1;
            check("random", model_q(m_state, clr, pre));
            m_state = model_next(m_state, rst, d, ce, clr, pre);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_fdxe_bank
